// File: rtl/vhd_ctrl_pkg.sv
// Shared types and constants for the virtual-disk sector arbiter.
package vhd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    WAIT_ACK = 3'd2,
    XFER     = 3'd3,
    DONE     = 3'd4
  } vhd_state_e;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;
  localparam int LBA_W        = 32;
  localparam int BYTE_W       = 8;

endpackage

// File: rtl/vhd_sector_buf.sv
// 512x8 true dual-port sector buffer: port A faces the requesters, port B the HPS.
module vhd_sector_buf
  import vhd_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SECTOR_AW-1:0] a_addr,
  input  logic [BYTE_W-1:0]    a_din,
  input  logic                 a_we,
  output logic [BYTE_W-1:0]    a_dout,
  input  logic [SECTOR_AW-1:0] b_addr,
  input  logic [BYTE_W-1:0]    b_din,
  input  logic                 b_we,
  output logic [BYTE_W-1:0]    b_dout
);

  logic [BYTE_W-1:0] mem_r [SECTOR_BYTES];
  logic [BYTE_W-1:0] a_dout_r;
  logic [BYTE_W-1:0] b_dout_r;

  // storage writes; deliberately not reset so late HPS writes still land
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_r[a_addr] <= a_din;
    end
    if (b_we) begin
      mem_r[b_addr] <= b_din;
    end
  end

  // registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      a_dout_r <= '0;
      b_dout_r <= '0;
    end else begin
      a_dout_r <= mem_r[a_addr];
      b_dout_r <= mem_r[b_addr];
    end
  end

  assign a_dout = a_dout_r;
  assign b_dout = b_dout_r;

endmodule

// File: rtl/vhd_sector_arbiter.sv
// Round-robin arbiter sharing the hps_io sector channel and buffer between N_REQ requesters.
// Optional macro VHD_TIMEOUT_EN adds an HPS acknowledge timeout.
module vhd_sector_arbiter
  import vhd_ctrl_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   img_mounted,
  input  logic [63:0]            img_size,
  output logic                   img_present,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_go,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [N_REQ*LBA_W-1:0] req_lba,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       req_done,
  output logic [N_REQ-1:0]       req_err,
  input  logic [SECTOR_AW-1:0]   buf_addr,
  input  logic [BYTE_W-1:0]      buf_din,
  input  logic                   buf_we,
  output logic [BYTE_W-1:0]      buf_dout,
  output logic                   busy,
  output logic                   sd_rd,
  output logic                   sd_wr,
  output logic [LBA_W-1:0]       sd_lba,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  input  logic [SECTOR_AW-1:0]   sd_buff_addr,
  input  logic [BYTE_W-1:0]      sd_buff_dout,
  output logic [BYTE_W-1:0]      sd_buff_din
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  vhd_state_e        state_r, state_s;
  logic [IDX_W-1:0]  holder_r, holder_s, rr_r, rr_s, pick_s;
  logic              wr_r, wr_s, err_s, tmo_hit_s;
  logic [LBA_W-1:0]  sd_lba_r, lba_s, capacity_r;
  logic              img_present_r, busy_r, sd_rd_r, sd_wr_r;
  logic [N_REQ-1:0]  gnt_r, req_done_r, req_err_r;
  logic [LBA_W-1:0]  lba_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lba
    assign lba_arr_s[g] = req_lba[g*LBA_W +: LBA_W];
  end

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef VHD_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] tmo_r;

  // the hit fires as the count would reach all-ones: 2^W-1 cycles in the state
  assign tmo_hit_s = (tmo_r == TMO_LAST);

  // ack-timeout counter, restarted on every state change
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_r <= '0;
    end else if (state_s != state_r) begin
      tmo_r <= '0;
    end else if (state_r == WAIT_ACK || state_r == XFER) begin
      tmo_r <= tmo_r + TIMEOUT_W'(1);
    end else begin
      tmo_r <= tmo_r;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // first valid requester at or after the round-robin pointer
  always_comb begin
    logic [IDX_W:0] sum;
    sum    = '0;
    pick_s = rr_r;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_r} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end else begin
        sum = sum;
      end
      pick_s = req_valid[sum[IDX_W-1:0]] ? sum[IDX_W-1:0] : pick_s;
    end
  end

  // next-state logic for grant and sector handshake
  always_comb begin
    state_s  = state_r;
    holder_s = holder_r;
    rr_s     = rr_r;
    wr_s     = wr_r;
    lba_s    = sd_lba_r;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          holder_s = pick_s;
          state_s  = GRANT;
        end else begin
          state_s  = IDLE;
        end
      end
      GRANT: begin
        if (!req_valid[holder_r]) begin
          rr_s    = (holder_r == IDX_W'(N_REQ - 1)) ? '0 : holder_r + IDX_W'(1);
          state_s = IDLE;
        end else if (req_go[holder_r]) begin
          wr_s = req_write[holder_r];
          if (!img_present_r || (lba_arr_s[holder_r] >= capacity_r)) begin
            err_s   = 1'b1;
            state_s = DONE;
          end else begin
            lba_s   = lba_arr_s[holder_r];
            state_s = WAIT_ACK;
          end
        end else begin
          state_s = GRANT;
        end
      end
      WAIT_ACK: begin
        if (sd_ack) begin
          state_s = XFER;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_s = DONE;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = DONE;
        end else begin
          state_s = XFER;
        end
      end
      DONE:    state_s = GRANT;
      default: state_s = IDLE;
    endcase
  end

  // state and registered outputs, all derived from the next state
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r       <= IDLE;
      holder_r      <= '0;
      rr_r          <= '0;
      wr_r          <= 1'b0;
      sd_lba_r      <= '0;
      capacity_r    <= '0;
      img_present_r <= 1'b0;
      busy_r        <= 1'b0;
      sd_rd_r       <= 1'b0;
      sd_wr_r       <= 1'b0;
      gnt_r         <= '0;
      req_done_r    <= '0;
      req_err_r     <= '0;
    end else begin
      state_r    <= state_s;
      holder_r   <= holder_s;
      rr_r       <= rr_s;
      wr_r       <= wr_s;
      sd_lba_r   <= lba_s;
      busy_r     <= (state_s != IDLE);
      sd_rd_r    <= (state_s == WAIT_ACK) && !wr_s;
      sd_wr_r    <= (state_s == WAIT_ACK) && wr_s;
      gnt_r      <= (state_s != IDLE) ? onehot(holder_s) : '0;
      req_done_r <= (state_s == DONE) ? onehot(holder_s) : '0;
      req_err_r  <= (state_s == DONE && err_s) ? onehot(holder_s) : '0;
      if (img_mounted) begin
        capacity_r    <= img_size[40:9];
        img_present_r <= |img_size;
      end else begin
        capacity_r    <= capacity_r;
        img_present_r <= img_present_r;
      end
    end
  end

  vhd_sector_buf u_buf (
    .clk    (clk_sys),
    .reset  (reset),
    .a_addr (buf_addr),
    .a_din  (buf_din),
    .a_we   (buf_we && (state_r == GRANT)),
    .a_dout (buf_dout),
    .b_addr (sd_buff_addr),
    .b_din  (sd_buff_dout),
    .b_we   (sd_buff_wr),
    .b_dout (sd_buff_din)
  );

  assign img_present = img_present_r;
  assign busy        = busy_r;
  assign sd_rd       = sd_rd_r;
  assign sd_wr       = sd_wr_r;
  assign sd_lba      = sd_lba_r;
  assign gnt         = gnt_r;
  assign req_done    = req_done_r;
  assign req_err     = req_err_r;

endmodule

// File: tb/tb_vhd_sector_arbiter.sv
// Directed plus randomized bench for vhd_sector_arbiter against a behavioural disk model.
module tb_vhd_sector_arbiter;

  localparam int N = 2;

  logic            clk_sys, reset, img_mounted, img_present;
  logic [63:0]     img_size;
  logic [N-1:0]    req_valid, req_go, req_write, gnt, req_done, req_err;
  logic [N*32-1:0] req_lba;
  logic [8:0]      buf_addr, sd_buff_addr;
  logic [7:0]      buf_din, buf_dout, sd_buff_dout, sd_buff_din;
  logic            buf_we, busy, sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [31:0]     sd_lba;

  int          tests, fails, hold_m, tmo_cycles;
  logic [7:0]  ref_mem [512];
  bit          present_m;
  logic [63:0] cap_m;

  vhd_sector_arbiter #(.N_REQ(N), .TIMEOUT_W(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .img_present(img_present), .req_valid(req_valid), .req_go(req_go),
    .req_write(req_write), .req_lba(req_lba), .gnt(gnt), .req_done(req_done),
    .req_err(req_err), .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we),
    .buf_dout(buf_dout), .busy(busy), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic mount(input logic [63:0] size);
    img_size = size; img_mounted = 1'b1; step(); img_mounted = 1'b0;
    present_m = (size != 64'd0);
    cap_m     = size / 64'd512;
    chk("img_present", img_present, present_m);
  endtask

  task automatic rd_buf(input int a);
    buf_addr = 9'(a); step();
    chk("buf_dout", buf_dout, ref_mem[a]);
  endtask

  // holder releases for one cycle and re-requests; next grant is first valid after it
  task automatic rotate();
    int nxt; bit found;
    req_valid[hold_m] = 1'b0; step();
    chk("rel_gnt", gnt, '0); chk("rel_busy", busy, 0);
    req_valid[hold_m] = 1'b1;
    nxt = hold_m; found = 0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_valid[(hold_m + k) % N]) begin
        nxt = (hold_m + k) % N; found = 1;
      end
    end
    step();
    chk("rr_gnt", gnt, oh(nxt));
    hold_m = nxt;
  endtask

  task automatic txn(input int r, input bit wr, input logic [31:0] lba, input bit pattern);
    bit rej; logic [7:0] b;
    rej = !present_m || (64'(lba) >= cap_m);
    req_lba[r*32 +: 32] = lba; req_write[r] = wr; req_go[r] = 1'b1;
    step(); req_go = '0;
    if (rej) begin
      chk("rej_done", req_done, oh(r)); chk("rej_err", req_err, oh(r));
      chk("rej_no_sd", {sd_rd, sd_wr}, 0);
      step(); chk("rej_done_pulse", req_done, '0);
      return;
    end
    chk("sd_rd", sd_rd, !wr); chk("sd_wr", sd_wr, wr); chk("sd_lba", sd_lba, lba);
    repeat ($urandom_range(0, 3)) begin
      step(); chk("sd_req_hold", sd_rd | sd_wr, 1);
    end
    sd_ack = 1'b1; step();
    chk("sd_req_drop", {sd_rd, sd_wr}, 0); chk("xfer_no_done", req_done, '0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      if (!wr) begin
        b = pattern ? 8'(i) : 8'($urandom);
        sd_buff_dout = b; sd_buff_wr = 1'b1; ref_mem[i] = b;
        step();
      end else begin
        // requester write attempt while HPS owns the buffer must be dropped
        if (i == 3) begin buf_addr = 9'd7; buf_din = ~ref_mem[7]; buf_we = 1'b1; end
        else buf_we = 1'b0;
        step();
        chk("hps_rd_byte", sd_buff_din, ref_mem[i]);
      end
    end
    sd_buff_wr = 1'b0; buf_we = 1'b0; sd_ack = 1'b0;
    step(); chk("done", req_done, oh(r)); chk("done_err", req_err, '0);
    step(); chk("done_pulse", req_done, '0); chk("gnt_kept", gnt, oh(r));
  endtask

  initial begin
    clk_sys = 1'b0; reset = 1'b1; img_mounted = 1'b0; img_size = '0;
    req_valid = 2'b11; req_go = '0; req_write = '0; req_lba = '0;
    buf_addr = '0; buf_din = '0; buf_we = 1'b0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
    tests = 0; fails = 0; hold_m = 0; present_m = 0; cap_m = '0; tmo_cycles = 0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;

    repeat (3) step();
    chk("rst_gnt", gnt, '0); chk("rst_busy", busy, 0); chk("rst_sd", {sd_rd, sd_wr}, 0);
    chk("rst_lba", sd_lba, 0); chk("rst_present", img_present, 0);
    chk("rst_done", {req_done, req_err}, 0); chk("rst_bufs", {buf_dout, sd_buff_din}, 0);

    reset = 1'b0; step();
    chk("first_gnt", gnt, oh(0)); chk("busy", busy, 1);
    hold_m = 0;

    txn(0, 1'b0, 32'd5, 1'b1);
    txn(0, 1'b1, 32'd0, 1'b1);

    mount(64'd1 << 20);
    txn(0, 1'b0, 32'd5, 1'b1);
    rd_buf(511); chk("buf_1ff", buf_dout, 8'hFF);
    rd_buf(0); rd_buf(128);

    rotate();
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i); buf_din = 8'hA5; buf_we = 1'b1; ref_mem[i] = 8'hA5; step();
    end
    buf_we = 1'b0;
    txn(hold_m, 1'b1, 32'd2047, 1'b0);
    txn(hold_m, 1'b0, 32'd2048, 1'b0);

    req_go[1 - hold_m] = 1'b1; step(); req_go = '0;
    chk("nonholder_sd", {sd_rd, sd_wr}, 0); chk("nonholder_done", req_done, '0);
    step(); chk("nonholder_gnt", gnt, oh(hold_m));

    repeat (3) rotate();

    for (int it = 0; it < 10; it++) begin
      bit wr; logic [31:0] lba; int a;
      if ($urandom_range(0, 1) == 1) rotate();
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) mount(64'd0);
        else mount(64'($urandom_range(1, 4096)) * 64'd512 + 64'($urandom_range(0, 511)));
      end
      wr  = 1'($urandom_range(0, 1));
      lba = 32'($urandom_range(0, 4200));
      if (wr) begin
        for (int k = 0; k < 8; k++) begin
          a = $urandom_range(0, 511);
          buf_addr = 9'(a); buf_din = 8'($urandom); buf_we = 1'b1; ref_mem[a] = buf_din;
          step();
        end
        buf_we = 1'b0;
      end
      txn(hold_m, wr, lba, 1'b0);
      rd_buf($urandom_range(0, 511)); rd_buf(511);
    end

    mount(64'd1 << 20);
    req_lba[hold_m*32 +: 32] = 32'd9; req_write[hold_m] = 1'b0; req_go[hold_m] = 1'b1;
    step(); req_go = '0;
    chk("mid_sd_rd", sd_rd, 1);
    sd_ack = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      sd_buff_addr = 9'(i); sd_buff_dout = 8'($urandom); ref_mem[i] = sd_buff_dout;
      sd_buff_wr = 1'b1; step();
    end
    sd_buff_wr = 1'b0;
    reset = 1'b1; step();
    chk("mid_rst_gnt", gnt, '0); chk("mid_rst_sd", {sd_rd, sd_wr}, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", {req_done, req_err}, 0);
    chk("mid_rst_present", img_present, 0); chk("mid_rst_lba", sd_lba, 0);
    reset = 1'b0; sd_ack = 1'b0; present_m = 0; cap_m = '0;
    step(); chk("post_rst_gnt", gnt, oh(0)); hold_m = 0;
    mount(64'd1 << 20);
    txn(0, 1'b0, 32'd100, 1'b0);
    rd_buf(0); rd_buf(511);

`ifdef VHD_TIMEOUT_EN
    req_lba[hold_m*32 +: 32] = 32'd1; req_write[hold_m] = 1'b0; req_go[hold_m] = 1'b1;
    step(); req_go = '0;
    tmo_cycles = 0;
    while (sd_rd && tmo_cycles < 40) begin
      tmo_cycles++; step();
    end
    chk("tmo_cycles", tmo_cycles, 15);
    chk("tmo_done", req_done, oh(hold_m)); chk("tmo_err", req_err, oh(hold_m));
    step(); chk("tmo_gnt", gnt, oh(hold_m));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
